// File: rtl/sample_capture.sv
// sample_capture: decimates the DUT output bus to the sample rate and buffers the
// captured samples in a first-word-fall-through FIFO behind a valid/ready handshake.
// Optional feature macro SAMPLE_TIMESTAMP_EN: each stored word carries a 32-bit
// sample index in its upper bits so the consumer can spot dropped samples.
module sample_capture #(
    parameter int DATA_WIDTH   = 16,
    parameter int DUT_CLK_FREQ = 100_000_000,
    parameter int SAMPLE_FREQ  = 1_000_000,
    parameter int DEPTH        = 16,
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int OUT_W       = DATA_WIDTH + 32
`else
    localparam int OUT_W       = DATA_WIDTH
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int DIV   = DUT_CLK_FREQ / SAMPLE_FREQ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(DEPTH);

    if (DIV < 1) begin : g_div_check
        $error("sample_capture: DUT_CLK_FREQ / SAMPLE_FREQ must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sample_capture: DEPTH must be a power of two, at least 2");
    end

    // Saturating increment for the 16-bit drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] wr_word;
    logic             strobe, empty, full, push, pop, drop;

`ifdef SAMPLE_TIMESTAMP_EN
    logic [31:0]      idx_q, idx_d;
    assign wr_word = {idx_q, in_data};
`else
    assign wr_word = in_data;
`endif

    // The strobe cycle is the last count of each sampling period.
    assign strobe = enable && (div_cnt_q == CNT_W'(DIV - 1));
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && out_ready;
    // A simultaneous pop frees the slot the push needs, so a full FIFO only drops without one.
    assign push   = strobe && (!full || pop);
    assign drop   = strobe && full && !pop;

    // Next-state logic for the decimation counter, pointers and overflow bookkeeping.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
`ifdef SAMPLE_TIMESTAMP_EN
        idx_d      = strobe ? idx_q + 32'd1 : idx_q;
`endif
        if (!enable || strobe) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end
    end

    // Control state registers; reset flushes the FIFO and restarts the sampling period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef SAMPLE_TIMESTAMP_EN
            idx_q      <= '0;
`endif
        end else begin
            div_cnt_q  <= div_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef SAMPLE_TIMESTAMP_EN
            idx_q      <= idx_d;
`endif
        end
    end

    // FIFO storage; cleared on reset so the head word reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
        end
    end

    assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid  = !empty;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sample_capture;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int OW    = DW + 32;
`else
    localparam int OW    = DW;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic [OW-1:0]  out_data;
    logic           out_valid;
    logic [2:0]     level;
    logic           overflow;
    logic [15:0]    drop_count;

    always #5 clk = ~clk;

    sample_capture #(
        .DATA_WIDTH  (DW),
        .DUT_CLK_FREQ(4_000_000),
        .SAMPLE_FREQ (1_000_000),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dpart(input logic [OW-1:0] w);
        return w[DW-1:0];
    endfunction

`ifdef SAMPLE_TIMESTAMP_EN
    function automatic logic [31:0] ipart(input logic [OW-1:0] w);
        return w[OW-1:DW];
    endfunction
    function automatic logic [OW-1:0] mk_word(input logic [31:0] idx, input logic [DW-1:0] d);
        return {idx, d};
    endfunction
`else
    function automatic logic [OW-1:0] mk_word(input logic [DW-1:0] d);
        return d;
    endfunction
`endif

    // Reference model: the FIFO is a queue, the sampling phase is the length of
    // the current unbroken run of enabled cycles.
    logic [OW-1:0] m_q[$];
    logic [OW-1:0] m_acc[$];
    logic [OW-1:0] d_acc[$];
    int            m_run = 0;
    bit            m_ovf = 0;
    int            m_drops = 0;
    bit            m_strobe, m_pop;
    int            vcount = 0;
    bit            chk_en = 0;
`ifdef SAMPLE_TIMESTAMP_EN
    logic [31:0]   m_idx = '0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_run   = 0;
            m_ovf   = 0;
            m_drops = 0;
`ifdef SAMPLE_TIMESTAMP_EN
            m_idx   = '0;
`endif
        end else begin
            m_strobe = enable && ((m_run % DIV) == DIV - 1);
            m_pop    = (m_q.size() != 0) && out_ready;
            if (m_pop) m_acc.push_back(m_q.pop_front());
            if (m_strobe) begin
                if (m_q.size() < DEPTH) begin
`ifdef SAMPLE_TIMESTAMP_EN
                    m_q.push_back(mk_word(m_idx, in_data));
`else
                    m_q.push_back(mk_word(in_data));
`endif
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
`ifdef SAMPLE_TIMESTAMP_EN
                m_idx = m_idx + 32'd1;
`endif
            end
            m_run = enable ? m_run + 1 : 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_q.size() != 0);
            check("level", level, m_q.size());
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drops);
            if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
            if (out_valid && out_ready) d_acc.push_back(out_data);
            if (out_valid) vcount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        d_acc.delete();
        m_acc.delete();
        vcount = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic chk_acc(input string name, input int i, input int exp_d);
        if (i < d_acc.size()) check(name, dpart(d_acc[i]), exp_d);
        if (i < m_acc.size()) check({name, "_model"}, dpart(m_acc[i]), exp_d);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        chk_en = 1;
        tick();
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drops", drop_count, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        clear_logs();

        // Decimation with a ready consumer
        for (int i = 0; i < 16; i++) begin
            enable = 1'b1; out_ready = 1'b1; in_data = DW'(i);
            tick();
        end
        enable = 1'b0;
        tick(); tick();
        check("dec_count", d_acc.size(), 4);
        chk_acc("dec_w0", 0, 3);
        chk_acc("dec_w1", 1, 7);
        chk_acc("dec_w2", 2, 11);
        chk_acc("dec_w3", 3, 15);
        check("dec_valid_cycles", vcount, 4);

        // Backpressure into overflow, then drain
        do_reset();
        for (int i = 0; i < 80; i++) begin
            enable = 1'b1; out_ready = 1'b0; in_data = DW'(i);
            tick();
        end
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 16);
        enable = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("ovf_read_count", d_acc.size(), 4);
        chk_acc("ovf_r0", 0, 3);
        chk_acc("ovf_r1", 1, 7);
        chk_acc("ovf_r2", 2, 11);
        chk_acc("ovf_r3", 3, 15);
`ifdef SAMPLE_TIMESTAMP_EN
        for (int i = 0; i < 4; i++) begin
            if (i < d_acc.size()) check("ovf_idx", ipart(d_acc[i]), i);
        end
`endif
        check("ovf_drained", level, 0);
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1; out_ready = 1'b0; in_data = DW'(100 + i);
            tick();
        end
        enable = 1'b0;
        check("post_drain_valid", out_valid, 1);
        check("post_drain_data", dpart(out_data), 103);
`ifdef SAMPLE_TIMESTAMP_EN
        check("post_drain_idx", ipart(out_data), 20);
`endif
        check("ovf_sticky", overflow, 1);

        // Full FIFO with a pop on the strobe edge
        do_reset();
        for (int i = 0; i < 19; i++) begin
            enable = 1'b1; out_ready = 1'b0; in_data = DW'(i);
            tick();
        end
        check("full_level", level, 4);
        out_ready = 1'b1; in_data = 16'd19;
        tick();
        out_ready = 1'b0; enable = 1'b0;
        check("fullpop_level", level, 4);
        check("fullpop_drops", drop_count, 0);
        check("fullpop_overflow", overflow, 0);
        check("fullpop_head", dpart(out_data), 7);
        check("fullpop_acc_count", d_acc.size(), 1);
        chk_acc("fullpop_acc", 0, 3);
        tick();

        // Enable gap discards the partial period
        do_reset();
        out_ready = 1'b1;
        for (int g = 0; g < 14; g++) begin
            enable = !(g >= 2 && g <= 6);
            in_data = DW'(g);
            tick();
        end
        enable = 1'b0;
        tick(); tick();
        check("gap_count", d_acc.size(), 1);
        chk_acc("gap_word", 0, 10);

        // Mid-run reset with level=3 and overflow set
        do_reset();
        for (int i = 0; i < 20; i++) begin
            enable = 1'b1; out_ready = 1'b0; in_data = DW'(i);
            tick();
        end
        enable = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; enable = 1'b1; in_data = 16'd50;
        tick(); tick();
        check("prerst_level", level, 3);
        check("prerst_overflow", overflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        check("midrst_level", level, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_drops", drop_count, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1; in_data = DW'(i);
            tick();
            if (i == 2) check("midrst_not_yet", out_valid, 0);
            if (i == 3) check("midrst_first", out_valid, 1);
        end
        enable = 1'b0;
        tick();
        check("midrst_count", d_acc.size(), 1);
        chk_acc("midrst_word", 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
